// File: rtl/mul16x16_seq_ctrl.sv
// 16x16 unsigned multiplier sequencer built around one shared 8x8 multiplier.
// Issues four partial products, realigns them, accumulates and hands back the 32-bit result.
module mul16x16_seq_ctrl #(
    parameter int PP_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic [7:0]  pp_a,
    output logic [7:0]  pp_b,
    input  logic [15:0] pp_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_p,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t      state;
    logic [1:0]  step;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [31:0] acc;
    logic [31:0] acc_nxt;
    logic [31:0] pp_sh;
    logic        iss_vld;
    logic [1:0]  iss_k;
    logic        cap_vld;
    logic [1:0]  cap_k;

    assign iss_vld  = (state == ISSUE);
    assign iss_k    = step;
    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    // Step tag follows the operands through the multiplier latency.
    generate
        if (PP_LAT == 0) begin : g_nolat
            assign cap_vld = iss_vld;
            assign cap_k   = iss_k;
        end else begin : g_lat
            logic [PP_LAT-1:0] vld_sr;
            logic [1:0]        k_sr [PP_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PP_LAT; i++) begin
                        vld_sr[i] <= 1'b0;
                        k_sr[i]   <= 2'd0;
                    end
                end else begin
                    vld_sr[0] <= iss_vld;
                    k_sr[0]   <= iss_k;
                    for (int i = 1; i < PP_LAT; i++) begin
                        vld_sr[i] <= vld_sr[i-1];
                        k_sr[i]   <= k_sr[i-1];
                    end
                end
            end

            assign cap_vld = vld_sr[PP_LAT-1];
            assign cap_k   = k_sr[PP_LAT-1];
        end
    endgenerate

    always_comb begin
        pp_sh = {16'h0000, pp_p};
        unique case (cap_k)
            2'd0:    pp_sh = {16'h0000, pp_p};
            2'd1:    pp_sh = {8'h00, pp_p, 8'h00};
            2'd2:    pp_sh = {8'h00, pp_p, 8'h00};
            2'd3:    pp_sh = {pp_p, 16'h0000};
            default: pp_sh = {16'h0000, pp_p};
        endcase
    end

    assign acc_nxt = acc + pp_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= 2'd0;
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            acc       <= 32'h0000_0000;
            pp_a      <= 8'h00;
            pp_b      <= 8'h00;
            out_valid <= 1'b0;
            out_p     <= 32'h0000_0000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        acc   <= 32'h0000_0000;
                        pp_a  <= in_a[7:0];
                        pp_b  <= in_b[7:0];
                        step  <= 2'd0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    step <= step + 2'd1;
                    unique case (step)
                        2'd0: begin
                            pp_a <= a_q[15:8];
                            pp_b <= b_q[7:0];
                        end
                        2'd1: begin
                            pp_a <= a_q[7:0];
                            pp_b <= b_q[15:8];
                        end
                        2'd2: begin
                            pp_a <= a_q[15:8];
                            pp_b <= b_q[15:8];
                        end
                        default: begin
                            pp_a  <= 8'h00;
                            pp_b  <= 8'h00;
                            state <= DRAIN;
                        end
                    endcase
                end
                DRAIN: begin
                    state <= DRAIN;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // The last partial product lands here; this overrides the DRAIN step.
            if (cap_vld) begin
                acc <= acc_nxt;
                if (cap_k == 2'd3) begin
                    out_p     <= acc_nxt;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
            end
        end
    end

endmodule
